// File: rtl/rc4_ksa_requester.sv
// RC4 key-scheduling engine: permutes an identity-initialised 256-byte S-memory with the
// secret key, issuing every read and write through one requester port of the S-memory arbiter.
module rc4_ksa_requester #(
    parameter int unsigned KEY_BYTES = 3,
    parameter int unsigned N         = 17,
    parameter int unsigned M         = 8
) (
    input  logic                   sm_clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    output logic                   busy,
    output logic                   done,
    output logic                   start_request,
    input  logic                   reset_start_request,
    input  logic                   finish,
    output logic [N-1:0]           output_arguments,
    input  logic [M-1:0]           received_data
);

    localparam int unsigned KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [KW-1:0] KIDX_LAST = KW'(KEY_BYTES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRdI,
        StCalc,
        StRdJ,
        StWrI,
        StWrJ,
        StNext,
        StFin
    } state_e;

    state_e                 state_q, state_d;
    logic [7:0]             i_q, i_d;
    logic [7:0]             j_q, j_d;
    logic [7:0]             si_q, si_d;
    logic [7:0]             sj_q, sj_d;
    logic [8*KEY_BYTES-1:0] key_q, key_d;
    logic [KW-1:0]          kidx_q, kidx_d;
    logic                   issued_q, issued_d;
    logic                   start_request_q, start_request_d;
    logic [N-1:0]           args_q, args_d;

    logic [7:0]             key_byte;
    logic [N-1:0]           xact_args;

    // Byte 0 of the key is its most significant byte.
    always_comb begin
        key_byte = 8'h00;
        for (int b = 0; b < int'(KEY_BYTES); b++) begin
            if (kidx_q == KW'(b)) begin
                key_byte = key_q[8*(int'(KEY_BYTES)-1-b) +: 8];
            end
        end
    end

    always_comb begin
        xact_args = '0;
        unique case (state_q)
            StRdI:   xact_args = {1'b0, i_q, 8'h00};
            StRdJ:   xact_args = {1'b0, j_q, 8'h00};
            StWrI:   xact_args = {1'b1, i_q, sj_q};
            StWrJ:   xact_args = {1'b1, j_q, si_q};
            default: xact_args = '0;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        i_d             = i_q;
        j_d             = j_q;
        si_d            = si_q;
        sj_d            = sj_q;
        key_d           = key_q;
        kidx_d          = kidx_q;
        issued_d        = issued_q;
        start_request_d = start_request_q;
        args_d          = args_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    key_d           = secret_key;
                    i_d             = 8'h00;
                    j_d             = 8'h00;
                    kidx_d          = '0;
                    state_d         = StRdI;
                    // First read goes out immediately so start_request follows start by one cycle.
                    issued_d        = 1'b1;
                    start_request_d = 1'b1;
                    args_d          = {1'b0, 8'h00, 8'h00};
                end
            end

            StRdI, StRdJ, StWrI, StWrJ: begin
                if (!issued_q) begin
                    issued_d        = 1'b1;
                    start_request_d = 1'b1;
                    args_d          = xact_args;
                end else begin
                    if (start_request_q && reset_start_request) begin
                        start_request_d = 1'b0;
                    end
                    if (finish) begin
                        issued_d        = 1'b0;
                        start_request_d = 1'b0;
                        unique case (state_q)
                            StRdI: begin
                                si_d    = received_data[7:0];
                                state_d = StCalc;
                            end
                            StRdJ: begin
                                sj_d    = received_data[7:0];
                                state_d = StWrI;
                            end
                            StWrI:   state_d = StWrJ;
                            default: state_d = StNext;
                        endcase
                    end
                end
            end

            StCalc: begin
                j_d     = j_q + si_q + key_byte;
                state_d = StRdJ;
            end

            StNext: begin
                if (i_q == 8'hFF) begin
                    state_d = StFin;
                end else begin
                    i_d     = i_q + 8'd1;
                    kidx_d  = (kidx_q == KIDX_LAST) ? '0 : kidx_q + KW'(1);
                    state_d = StRdI;
                end
            end

            StFin:   state_d = StIdle;

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sm_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= StIdle;
            i_q             <= 8'h00;
            j_q             <= 8'h00;
            si_q            <= 8'h00;
            sj_q            <= 8'h00;
            key_q           <= '0;
            kidx_q          <= '0;
            issued_q        <= 1'b0;
            start_request_q <= 1'b0;
            args_q          <= '0;
        end else begin
            state_q         <= state_d;
            i_q             <= i_d;
            j_q             <= j_d;
            si_q            <= si_d;
            sj_q            <= sj_d;
            key_q           <= key_d;
            kidx_q          <= kidx_d;
            issued_q        <= issued_d;
            start_request_q <= start_request_d;
            args_q          <= args_d;
        end
    end

    assign start_request    = start_request_q;
    assign output_arguments = args_q;
    assign busy             = (state_q != StIdle);
    assign done             = (state_q == StFin);

endmodule

// File: tb/tb_rc4_ksa_requester.sv
// Bench for rc4_ksa_requester: behavioural arbiter with S-memory, software KSA reference,
// directed passes covering handshake, index arithmetic, ignored start and mid-pass reset.
module tb_rc4_ksa_requester;

    logic        sm_clk;
    logic        reset_n;
    logic        start;
    logic [23:0] secret_key;
    logic        busy;
    logic        done;
    logic        start_request;
    logic        reset_start_request;
    logic        finish;
    logic        finish_arb;
    logic        finish_spur;
    logic [16:0] output_arguments;
    logic [7:0]  received_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  mem   [256];
    logic [7:0]  ref_s [256];
    logic [16:0] tx_log[1024];

    int tx_count  = 0;
    int tx_base   = 0;
    int viol      = 0;
    int fixed_dly = 0;
    int init_gen  = 0;
    int init_pat  = 0;

    assign finish = finish_arb | finish_spur;

    rc4_ksa_requester dut (
        .sm_clk              (sm_clk),
        .reset_n             (reset_n),
        .start               (start),
        .secret_key          (secret_key),
        .busy                (busy),
        .done                (done),
        .start_request       (start_request),
        .reset_start_request (reset_start_request),
        .finish              (finish),
        .output_arguments    (output_arguments),
        .received_data       (received_data)
    );

    initial sm_clk = 1'b0;
    always #5 sm_clk = ~sm_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Arbiter model: grant after a delay, then one cycle later perform the access and pulse finish.
    initial begin
        int          ph;
        int          wait_cnt;
        int          idx;
        int          init_seen;
        logic [16:0] cap;
        ph                  = 0;
        wait_cnt            = 0;
        init_seen           = 0;
        cap                 = '0;
        reset_start_request = 1'b0;
        finish_arb          = 1'b0;
        received_data       = 8'h00;
        forever begin
            @(posedge sm_clk);
            #1;
            if (init_gen != init_seen) begin
                init_seen = init_gen;
                for (int k = 0; k < 256; k++) mem[k] = 8'(k);
                if (init_pat == 1) begin
                    mem[0] = 8'hC0;
                    mem[1] = 8'h20;
                end
            end
            if (!reset_n) begin
                ph                  = 0;
                reset_start_request = 1'b0;
                finish_arb          = 1'b0;
                received_data       = 8'h00;
            end else begin
                case (ph)
                    0: if (start_request) begin
                        cap = output_arguments;
                        idx = tx_count - tx_base;
                        if (idx >= 0 && idx < 1024) tx_log[idx] = cap;
                        tx_count++;
                        wait_cnt = (fixed_dly != 0) ? fixed_dly : int'($urandom_range(5, 1));
                        ph = 1;
                    end
                    1: begin
                        if (start_request !== 1'b1 || output_arguments !== cap) viol++;
                        wait_cnt--;
                        if (wait_cnt == 0) begin
                            reset_start_request = 1'b1;
                            ph = 2;
                        end
                    end
                    2: begin
                        reset_start_request = 1'b0;
                        if (start_request !== 1'b0 || output_arguments !== cap) viol++;
                        ph = 3;
                    end
                    3: begin
                        if (start_request !== 1'b0 || output_arguments !== cap) viol++;
                        if (cap[16]) mem[cap[15:8]] = cap[7:0];
                        else received_data = mem[cap[15:8]];
                        finish_arb = 1'b1;
                        ph = 4;
                    end
                    default: begin
                        finish_arb    = 1'b0;
                        received_data = 8'h00;
                        ph = 0;
                    end
                endcase
            end
        end
    end

    task automatic ksa_ref(input logic [23:0] key);
        logic [7:0] j;
        logic [7:0] t;
        logic [7:0] kb;
        for (int k = 0; k < 256; k++) ref_s[k] = 8'(k);
        j = 8'h00;
        for (int i = 0; i < 256; i++) begin
            kb       = 8'(key >> (8 * (2 - (i % 3))));
            j        = j + ref_s[i] + kb;
            t        = ref_s[i];
            ref_s[i] = ref_s[j];
            ref_s[j] = t;
        end
    endtask

    function automatic int s_mismatches();
        int m = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== ref_s[k]) m++;
        return m;
    endfunction

    task automatic load_mem(input int pat);
        init_pat = pat;
        init_gen++;
        repeat (2) @(posedge sm_clk);
        #2;
    endtask

    // Runs one pass; returns early once abort_at transactions have been seen.
    task automatic run_pass(input logic [23:0] key, input int pulse_at, input int abort_at,
                            output int dones);
        int  n;
        int  tail;
        bit  pulsed;
        bit  seen;
        dones      = 0;
        tail       = 0;
        pulsed     = 1'b0;
        seen       = 1'b0;
        tx_base    = tx_count;
        secret_key = key;
        @(posedge sm_clk);
        #2;
        start = 1'b1;
        @(posedge sm_clk);
        #2;
        start = 1'b0;
        check_eq("start_busy", 32'(busy), 1);
        check_eq("start_req", 32'(start_request), 1);
        check_eq("start_args", 32'(output_arguments), 0);
        for (int cyc = 0; cyc < 25000; cyc++) begin
            @(posedge sm_clk);
            #2;
            start = 1'b0;
            n = tx_count - tx_base;
            if (pulse_at >= 0 && !pulsed && n >= pulse_at) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end
            if (abort_at >= 0 && n >= abort_at) return;
            if (done) dones++;
            if (seen) begin
                if (tail == 20) begin
                    check_eq("post_done_busy", 32'(busy), 0);
                    check_eq("post_done_done", 32'(done), 0);
                end
                tail--;
                if (tail == 0) return;
            end else if (done) begin
                seen = 1'b1;
                tail = 20;
                check_eq("done_with_busy", 32'(busy), 1);
            end
        end
        check_eq("pass_timeout", 0, 1);
    endtask

    initial begin
        int d;
        int v0;
        reset_n     = 1'b0;
        start       = 1'b0;
        secret_key  = '0;
        finish_spur = 1'b0;
        repeat (3) @(posedge sm_clk);
        #2;
        check_eq("rst_start_request", 32'(start_request), 0);
        check_eq("rst_args", 32'(output_arguments), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        reset_n = 1'b1;
        load_mem(0);

        // Stray finish with nothing outstanding must be ignored.
        finish_spur = 1'b1;
        @(posedge sm_clk);
        #2;
        finish_spur = 1'b0;
        @(posedge sm_clk);
        #2;
        check_eq("spur_busy", 32'(busy), 0);
        check_eq("spur_req", 32'(start_request), 0);

        // Golden pass, random grant delays, extra start at iteration 10.
        v0 = viol;
        ksa_ref(24'h000249);
        run_pass(24'h000249, 40, -1, d);
        check_eq("gold_dones", 32'(d), 1);
        check_eq("gold_tx", 32'(tx_count - tx_base), 1024);
        check_eq("gold_s", 32'(s_mismatches()), 0);
        check_eq("gold_viol", 32'(viol - v0), 0);
        check_eq("gold_tx1", 32'(tx_log[1]), 32'h00000);
        check_eq("gold_tx2_ieqj", 32'(tx_log[2]), 32'h10000);
        check_eq("gold_tx3_ieqj", 32'(tx_log[3]), 32'h10000);
        check_eq("gold_tx4", 32'(tx_log[4]), 32'h00100);
        check_eq("gold_tx5", 32'(tx_log[5]), 32'h00300);
        check_eq("gold_tx6", 32'(tx_log[6]), 32'h10103);
        check_eq("gold_tx7", 32'(tx_log[7]), 32'h10301);
        check_eq("gold_tx9", 32'(tx_log[9]), 32'h04E00);
        check_eq("gold_tx1020", 32'(tx_log[1020]), 32'h0FF00);
        check_eq("gold_tx1022_hi", 32'(tx_log[1022][16:8]), 32'h1FF);
        check_eq("i_hold_255", 32'(dut.i_q), 255);

        // Fixed 4-cycle grant delay.
        load_mem(0);
        fixed_dly = 4;
        v0 = viol;
        ksa_ref(24'h1A2B3C);
        run_pass(24'h1A2B3C, -1, -1, d);
        check_eq("hs_dones", 32'(d), 1);
        check_eq("hs_tx", 32'(tx_count - tx_base), 1024);
        check_eq("hs_s", 32'(s_mismatches()), 0);
        check_eq("hs_viol", 32'(viol - v0), 0);
        fixed_dly = 0;

        // j = F0 + 20 + 30 wraps to 40 in iteration 1.
        load_mem(1);
        run_pass(24'h303000, -1, 8, d);
        reset_n = 1'b0;
        repeat (2) @(posedge sm_clk);
        #2;
        reset_n = 1'b1;
        check_eq("idx_tx1", 32'(tx_log[1]), 32'h0F000);
        check_eq("idx_tx2", 32'(tx_log[2]), 32'h100F0);
        check_eq("idx_tx3", 32'(tx_log[3]), 32'h1F0C0);
        check_eq("idx_tx5_wrap", 32'(tx_log[5]), 32'h04000);
        check_eq("idx_tx6", 32'(tx_log[6]), 32'h10140);
        check_eq("idx_tx7", 32'(tx_log[7]), 32'h14020);

        // Reset at iteration 100, then a full pass from re-initialised S.
        load_mem(0);
        run_pass(24'h5A0F33, -1, 400, d);
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_req", 32'(start_request), 0);
        check_eq("mid_rst_args", 32'(output_arguments), 0);
        check_eq("mid_rst_busy", 32'(busy), 0);
        check_eq("mid_rst_done", 32'(done), 0);
        repeat (3) @(posedge sm_clk);
        #2;
        reset_n = 1'b1;
        load_mem(0);
        v0 = viol;
        ksa_ref(24'h0A0B0C);
        run_pass(24'h0A0B0C, -1, -1, d);
        check_eq("rerun_dones", 32'(d), 1);
        check_eq("rerun_tx", 32'(tx_count - tx_base), 1024);
        check_eq("rerun_s", 32'(s_mismatches()), 0);
        check_eq("rerun_viol", 32'(viol - v0), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rc4_ksa_requester.md
# rc4_ksa_requester

RC4 key-scheduling (KSA) engine for the RC4 decryption datapath. It permutes the 256-byte S-memory, which must hold S[k]=k beforehand, using the secret key. All S-memory traffic goes through one requester port of the shared S-memory arbiter, using its start/reset-start/finish handshake. It sits directly upstream of the arbiter and downstream of the S-memory initialiser.

## Interface
Parameters:
- KEY_BYTES, 3: key length in bytes.
- N, 17: arbiter argument width, {wren, address[7:0], write_data[7:0]}.
- M, 8: arbiter read-data width.

Ports:
- sm_clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a KSA pass; ignored unless in IDLE.
- secret_key  in  8*KEY_BYTES  key; byte 0 = MSB byte. Sampled at start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the pass completes.
- start_request  out  1  arbiter request.
- reset_start_request  in  1  arbiter acknowledge of the request.
- finish  in  1  arbiter transaction complete; read data valid this cycle.
- output_arguments  out  N  {wren, address, write_data} to the arbiter.
- received_data  in  M  read data from the arbiter.

## Operation
- Internal registers: i[7:0], j[7:0], si[7:0], sj[7:0], key_q, kidx (i mod KEY_BYTES, 0..KEY_BYTES-1).
- States:
  - IDLE: on start, latch the key and clear i, j and kidx; go to RD_I.
  - RD_I: read S[i]; capture si at finish; go to CALC.
  - CALC: j <= j + si + key_q byte[kidx], mod 256 (8-bit wrap, carries discarded); go to RD_J.
  - RD_J: read S[j]; capture sj; go to WR_I.
  - WR_I: write sj to address i; go to WR_J.
  - WR_J: write si to address j; go to NEXT.
  - NEXT: if i==255, go to FIN. Otherwise i++, kidx wraps from KEY_BYTES-1 to 0, go to RD_I.
  - FIN: assert done; go to IDLE.
- Transaction protocol, used in every RD_/WR_ state:
  - Cycle 1: set start_request=1 and drive output_arguments. Reads use wren=0 and write_data=0.
  - Hold start_request until reset_start_request is sampled high, then drop it the next cycle.
  - Hold output_arguments constant from request until finish.
  - On finish: capture received_data (reads only), then advance.
  - A finish that arrives while no request is outstanding is ignored.
- When i==j, both writes still occur at the same address; the second write (si) wins, which preserves S.
- start pulses during busy have no effect and are not queued.

## Timing
- Reset values: start_request=0, output_arguments=0, busy=0, done=0; i=j=si=sj=kidx=0; state IDLE.
- Reset asserted mid-pass: immediate return to IDLE with all outputs at reset values. The S-memory contents are left partially permuted; software re-initialises the S-memory.
- start high at clock edge t: busy=1 and start_request=1 from t+1.
- output_arguments is registered and changes only on the cycle start_request rises.
- Per transaction: at least 1 cycle between finish and the next start_request rise (state advance).
- CALC, NEXT and FIN each take exactly 1 cycle.
- done is high for exactly one cycle, the cycle after NEXT with i==255; busy falls in the same cycle done falls.
- Exactly 1024 arbiter transactions per pass: 256 iterations × (2 reads + 2 writes).

## Test plan
- Golden pass: S[k]=k, KEY_BYTES=3, secret_key=24'h000249, bench arbiter model with random 1-5 cycle grant delays -> final S equals the software-KSA reference for all 256 bytes; done pulses once; 1024 transactions counted.
- Handshake: reset_start_request delayed 4 cycles -> start_request stays high, output_arguments stable until finish; no second request before finish.
- Index arithmetic: force j=8'hF0, S[i]=8'h20, key byte 8'h30 -> j=8'h40. At i==255, next state is FIN and i stays at 255.
- i==j iteration: key chosen so that j==i at i=0 -> two writes to address 0, final S[0] unchanged.
- start pulsed at iteration 10 of a pass -> ignored; exactly one done.
- reset_n low at iteration 100 -> outputs cleared asynchronously; a new start afterwards runs a full, correct 1024-transaction pass from re-initialised S.
